axis_8b10b_encoder: RTL
=======================

Name: axis_8b10b_encoder

Overview:
Transmit-side 8b/10b encoder. It sits directly downstream of the AXIS byte-strobing interface and consumes its byte stream, one byte per handshake. Each byte becomes a 10-bit code group with running-disparity tracking. When no byte is offered, it fills the line with K28.5 idle commas. Output is one registered 10-bit code group per cycle toward the serializer.

Parameters:
IDLE_FILL, 1, 1 = emit K28.5 when no input is valid; 0 = o_code_valid low when idle
COMMA_PERIOD, 16, data words between forced commas (used only with ENC_COMMA_INSERT_EN); must be >= 2

Ports:
aclk  input  1  clock
reset  input  1  synchronous active-high reset
i_data  input  8  byte to encode, bits HGFEDCBA
i_is_k  input  1  byte is a control (K) character
i_valid  input  1  upstream byte valid
o_ready  output  1  byte accepted when i_valid && o_ready
o_code  output  10  code group; o_code[0]=a (first transmitted), order {j,h,g,f,i,e,d,c,b,a}
o_code_valid  output  1  o_code valid
i_code_ready  input  1  downstream accepts o_code
o_is_idle  output  1  current o_code is an inserted comma, not upstream data
o_k_err  output  1  current o_code replaced an illegal K request
o_rd  output  1  running disparity after the current o_code (0 = RD-, 1 = RD+)

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Reset is sampled only on the aclk rising edge.
- Reset values: o_code=0, o_code_valid=0, o_is_idle=0, o_k_err=0, o_rd=0 (RD-), comma counter=0.
- Pipeline: one output register stage. Latency is 1 cycle from an accepted byte to o_code_valid.
- Ready rule: o_ready = (!o_code_valid || i_code_ready) && !force_comma. This is combinational.
  - force_comma is always 0 unless ENC_COMMA_INSERT_EN is defined.
- Load slot: a load slot exists when !o_code_valid || i_code_ready. In a load slot:
  - If i_valid && !force_comma: encode i_data, o_is_idle=0.
  - Else if force_comma, or IDLE_FILL=1: load K28.5, o_is_idle=1.
  - Else: o_code_valid<=0.
- Stall: when o_code_valid && !i_code_ready, o_code, o_is_idle, o_k_err and o_rd hold. No input byte is accepted.
- Encoding: standard IEEE 802.3 clause 36 5b/6b + 3b/4b tables.
  - The 3b/4b lookup uses the RD produced by the 6b sub-block.
  - D.x.A7 alternate (1110/0001) is used when RD- and x in {17,18,20}, or RD+ and x in {11,13,14}.
  - o_rd updates from the disparity of the whole 10-bit group, only when a new group loads.
- Legal K: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7.
  - Any other i_is_k byte is encoded as K28.5 with o_k_err=1 for that group. It is still consumed.
- Reference codes:
  - K28.5: RD- gives 0x17C, RD+ gives 0x283. Each flips RD.
  - D0.0: RD- gives 0x0B9, RD+ gives 0x346. RD is unchanged.
- Reset asserted mid-stream:
  - The next cycle returns to reset values.
  - A byte offered in the reset cycle is not accepted (o_ready is forced 0 while reset=1).
  - The group being presented is dropped.
- Simultaneous i_valid and force_comma: the comma wins and the byte waits. No byte is lost or duplicated.

Optional Feature:
Macro ENC_COMMA_INSERT_EN.
- Defined:
  - A counter counts accepted data bytes. It saturates at COMMA_PERIOD.
  - When count == COMMA_PERIOD, force_comma=1. The next load slot emits K28.5 with o_is_idle=1 and o_ready=0, then the counter clears.
  - Any idle K28.5 emitted also clears the counter.
- Not defined: no counter, force_comma tied 0. Commas appear only through IDLE_FILL.

Test Plan:
1. Reset, i_valid=0, IDLE_FILL=1, i_code_ready=1 -> o_code sequence 0x17C, 0x283, 0x17C… with o_is_idle=1 and o_rd toggling 1,0,1.
2. Stream D0.0 ×4 from RD- -> four groups of 0x0B9, o_rd stays 0, 1-cycle latency from handshake.
3. Hold i_code_ready=0 for 3 cycles while i_valid=1 -> o_code stable, o_ready=0, no byte consumed. On release each byte appears exactly once, in order.
4. Send illegal K (i_data=0x00, i_is_k=1) at RD- -> o_code=0x17C, o_k_err=1 for that group only, o_rd=1.
5. ENC_COMMA_INSERT_EN, COMMA_PERIOD=4, continuous i_valid -> after every 4 data groups one K28.5 with o_is_idle=1; o_ready low exactly in that slot.
6. Assert reset for 1 cycle mid-stream at RD+ -> next cycle o_code_valid=0, o_rd=0; first post-reset idle is 0x17C.

Source files
------------

// File: rtl/axis_8b10b_encoder_if.sv
// Byte-stream in / code-group out bundle for the 8b/10b encoder.
// master = byte source plus code sink, slave = encoder.
interface axis_8b10b_encoder_if;
   logic [7:0] i_data;
   logic       i_is_k;
   logic       i_valid;
   logic       o_ready;
   logic [9:0] o_code;
   logic       o_code_valid;
   logic       i_code_ready;
   logic       o_is_idle;
   logic       o_k_err;
   logic       o_rd;

   modport master (
      output i_data, i_is_k, i_valid, i_code_ready,
      input  o_ready, o_code, o_code_valid, o_is_idle, o_k_err, o_rd
   );

   modport slave (
      input  i_data, i_is_k, i_valid, i_code_ready,
      output o_ready, o_code, o_code_valid, o_is_idle, o_k_err, o_rd
   );
endinterface

// File: rtl/axis_8b10b_encoder.sv
// 8b/10b encoder with running disparity and K28.5 idle fill.
// Optional periodic comma insertion: define ENC_COMMA_INSERT_EN.
module axis_8b10b_encoder #(
   parameter bit          IDLE_FILL    = 1'b1,
   parameter int unsigned COMMA_PERIOD = 16
) (
   input logic                 aclk,
   input logic                 reset,
   axis_8b10b_encoder_if.slave bus
);

   // 5b/6b codes in abcdei order, RD- column
   function automatic logic [5:0] tbl6(input logic [4:0] x);
      case (x)
         5'd0:  tbl6 = 6'b100111;
         5'd1:  tbl6 = 6'b011101;
         5'd2:  tbl6 = 6'b101101;
         5'd3:  tbl6 = 6'b110001;
         5'd4:  tbl6 = 6'b110101;
         5'd5:  tbl6 = 6'b101001;
         5'd6:  tbl6 = 6'b011001;
         5'd7:  tbl6 = 6'b111000;
         5'd8:  tbl6 = 6'b111001;
         5'd9:  tbl6 = 6'b100101;
         5'd10: tbl6 = 6'b010101;
         5'd11: tbl6 = 6'b110100;
         5'd12: tbl6 = 6'b001101;
         5'd13: tbl6 = 6'b101100;
         5'd14: tbl6 = 6'b011100;
         5'd15: tbl6 = 6'b010111;
         5'd16: tbl6 = 6'b011011;
         5'd17: tbl6 = 6'b100011;
         5'd18: tbl6 = 6'b010011;
         5'd19: tbl6 = 6'b110010;
         5'd20: tbl6 = 6'b001011;
         5'd21: tbl6 = 6'b101010;
         5'd22: tbl6 = 6'b011010;
         5'd23: tbl6 = 6'b111010;
         5'd24: tbl6 = 6'b110011;
         5'd25: tbl6 = 6'b100110;
         5'd26: tbl6 = 6'b010110;
         5'd27: tbl6 = 6'b110110;
         5'd28: tbl6 = 6'b001110;
         5'd29: tbl6 = 6'b101110;
         5'd30: tbl6 = 6'b011110;
         default: tbl6 = 6'b101011;
      endcase
   endfunction

   function automatic logic [3:0] tbl4d(input logic [2:0] y);
      case (y)
         3'd0: tbl4d = 4'b1011;
         3'd1: tbl4d = 4'b1001;
         3'd2: tbl4d = 4'b0101;
         3'd3: tbl4d = 4'b1100;
         3'd4: tbl4d = 4'b1101;
         3'd5: tbl4d = 4'b1010;
         3'd6: tbl4d = 4'b0110;
         default: tbl4d = 4'b1110;
      endcase
   endfunction

   function automatic logic [3:0] tbl4k(input logic [2:0] y);
      case (y)
         3'd0: tbl4k = 4'b1011;
         3'd1: tbl4k = 4'b0110;
         3'd2: tbl4k = 4'b1010;
         3'd3: tbl4k = 4'b1100;
         3'd4: tbl4k = 4'b1101;
         3'd5: tbl4k = 4'b0101;
         3'd6: tbl4k = 4'b1001;
         default: tbl4k = 4'b0111;
      endcase
   endfunction

   function automatic logic k_legal(input logic [7:0] d);
      logic [4:0] x;
      x = d[4:0];
      k_legal = (x == 5'd28) ||
                (d[7:5] == 3'd7 &&
                 (x == 5'd23 || x == 5'd27 ||
                  x == 5'd29 || x == 5'd30));
   endfunction

   // Returns {rd_after, abcdei, fghj}; illegal K maps to K28.5
   function automatic logic [10:0] enc(
      input logic [7:0] d,
      input logic       k,
      input logic       rd
   );
      logic [4:0] x;
      logic [2:0] y;
      logic [5:0] s6;
      logic [3:0] s4;
      logic       rd6;
      logic       alt;
      x = d[4:0];
      y = d[7:5];
      if (k && !k_legal(d)) begin
         x = 5'd28;
         y = 3'd5;
      end
      s6 = (k && x == 5'd28) ? 6'b001111 : tbl6(x);
      if (rd && ($countones(s6) != 3 || x == 5'd7))
         s6 = ~s6;
      rd6 = rd ^ ($countones(s6) != 3);
      alt = 1'b0;
      if (k) begin
         s4 = tbl4k(y);
         if (rd6) s4 = ~s4;
      end else begin
         alt = (y == 3'd7) &&
               ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
         s4 = alt ? 4'b0111 : tbl4d(y);
         if (rd6 && ($countones(s4) != 2 || y == 3'd3))
            s4 = ~s4;
      end
      enc = {rd6 ^ ($countones(s4) != 2), s6, s4};
   endfunction

   function automatic logic [9:0] rev10(input logic [9:0] v);
      for (int i = 0; i < 10; i++) rev10[i] = v[9-i];
   endfunction

   logic [9:0]  code_q, code_d;
   logic        vld_q, vld_d;
   logic        idle_q, idle_d;
   logic        kerr_q, kerr_d;
   logic        rd_q, rd_d;
   logic        slot, take, load_k, force_comma;
   logic [10:0] enc_dat, enc_k;

   assign enc_dat = enc(bus.i_data, bus.i_is_k, rd_q);
   assign enc_k   = enc(8'hBC, 1'b1, rd_q);

   assign slot        = !vld_q || bus.i_code_ready;
   assign bus.o_ready = slot && !force_comma && !reset;
   assign take        = bus.i_valid && bus.o_ready;
   assign load_k      = slot && !take && (force_comma || IDLE_FILL);

`ifdef ENC_COMMA_INSERT_EN
   localparam int unsigned CW = $clog2(COMMA_PERIOD + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign force_comma = (cnt_q == CW'(COMMA_PERIOD));

   always_comb begin
      cnt_d = cnt_q;
      if (load_k)
         cnt_d = '0;
      else if (take && !force_comma)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge aclk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign force_comma = 1'b0;
`endif

   always_comb begin
      code_d = code_q;
      vld_d  = vld_q;
      idle_d = idle_q;
      kerr_d = kerr_q;
      rd_d   = rd_q;
      if (take) begin
         code_d = rev10(enc_dat[9:0]);
         rd_d   = enc_dat[10];
         vld_d  = 1'b1;
         idle_d = 1'b0;
         kerr_d = bus.i_is_k && !k_legal(bus.i_data);
      end else if (load_k) begin
         code_d = rev10(enc_k[9:0]);
         rd_d   = enc_k[10];
         vld_d  = 1'b1;
         idle_d = 1'b1;
         kerr_d = 1'b0;
      end else if (slot) begin
         vld_d  = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         code_q <= '0;
         vld_q  <= 1'b0;
         idle_q <= 1'b0;
         kerr_q <= 1'b0;
         rd_q   <= 1'b0;
      end else begin
         code_q <= code_d;
         vld_q  <= vld_d;
         idle_q <= idle_d;
         kerr_q <= kerr_d;
         rd_q   <= rd_d;
      end
   end

   assign bus.o_code       = code_q;
   assign bus.o_code_valid = vld_q;
   assign bus.o_is_idle    = idle_q;
   assign bus.o_k_err      = kerr_q;
   assign bus.o_rd         = rd_q;

endmodule
